// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, 1-cycle imem requester and {pc, inst} prefetch FIFO
module instruction_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_data,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   output logic [31:0]           inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  inst_ready
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
   logic [31:0]           r_fifo_inst [FIFO_DEPTH];
   logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]         r_count;
   logic [ADDR_WIDTH-1:0] r_fetch_pc, r_req_pc, r_inst_pc;
   logic [31:0]           r_inst;
   logic                  r_inflight;

   logic                  w_valid, w_pop, w_push, w_room, w_issue;
   logic [CW:0]           w_occ;
   logic [CW-1:0]         w_cnt_after_pop;
   logic [PW-1:0]         w_rd_ptr_nxt;
   logic                  w_unused_bits;

   assign w_valid         = (r_count != '0);
   assign w_pop           = w_valid & inst_ready & ~redirect;
   assign w_push          = r_inflight & ~redirect;
   assign w_occ           = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign w_room          = (w_occ < (CW+1)'(FIFO_DEPTH));
   assign w_issue         = ~Reset & ~redirect & (w_room | w_pop);
   assign w_cnt_after_pop = w_pop ? r_count - CW'(1) : r_count;
   assign w_rd_ptr_nxt    = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
   assign w_unused_bits   = ^redirect_pc[1:0];

   assign imem_req   = w_issue;
   assign imem_addr  = r_fetch_pc;
   assign inst_valid = w_valid & ~Reset;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_inst     <= '0;
         r_inst_pc  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_pc[i]   <= '0;
            r_fifo_inst[i] <= '0;
         end
      end else if (redirect) begin
         // wrong-path entries and the in-flight response are dropped; head fields hold
         r_fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
         end
         if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
            r_fifo_inst[r_wr_ptr] <= imem_data;
            r_wr_ptr              <= r_wr_ptr + PW'(1);
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_push ? w_cnt_after_pop + CW'(1) : w_cnt_after_pop;
         // head registers track the next head; a push into an empty FIFO bypasses storage
         if (w_cnt_after_pop != '0) begin
            r_inst    <= r_fifo_inst[w_rd_ptr_nxt];
            r_inst_pc <= r_fifo_pc[w_rd_ptr_nxt];
         end else if (w_push) begin
            r_inst    <= imem_data;
            r_inst_pc <= r_req_pc;
         end
      end
   end
endmodule
